// File: rtl/acc_div_stream.sv
// acc_div_stream - streaming restoring divider with a show-ahead result buffer.
//
// Operands arrive as a dividend word followed by a divisor word on InputData,
// each qualified by StartData while ReadyToAccept is high. A WIDTH-step
// restoring divider produces the quotient, which is written together with a
// divide-by-zero flag into a DEPTH-entry show-ahead buffer. The consumer pops
// the head entry with ReceiveData.
//
// Optional feature macro: ACC_DIV_REMAINDER_EN
//   defined   - every operand pair also pushes its remainder (after the quotient)
//   undefined - only the quotient is buffered
//
// Ports:
//   clk            rising-edge clock
//   rstN           asynchronous active-low reset
//   StartData      operand strobe (honoured only while ReadyToAccept=1)
//   InputData      operand word (dividend first, then divisor)
//   ReadyToAccept  high in the operand-capture states
//   ReceiveData    pop strobe for the buffer head
//   OutputData     head entry value (0 while empty)
//   OutValid       buffer not empty
//   OutDivZero     divide-by-zero flag of the head entry (0 while empty)
//   OutBuffFull    buffer holds DEPTH entries
//   BuffCount      buffer occupancy
module acc_div_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         StartData,
  input  logic [WIDTH-1:0]             InputData,
  output logic                         ReadyToAccept,
  input  logic                         ReceiveData,
  output logic [WIDTH-1:0]             OutputData,
  output logic                         OutValid,
  output logic                         OutDivZero,
  output logic                         OutBuffFull,
  output logic [$clog2(DEPTH+1)-1:0]   BuffCount
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    CALC,
    PUSH_Q
`ifdef ACC_DIV_REMAINDER_EN
    , PUSH_R
`endif
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_dvs;
  logic [WIDTH-1:0]     r_prem;
  logic [WIDTH-1:0]     r_quot;
  logic [CW-1:0]        r_cnt;
  logic                 r_dz;

  logic [WIDTH:0]       r_mem [DEPTH];
  logic [PW-1:0]        r_wr;
  logic [PW-1:0]        r_rd;
  logic [NW-1:0]        r_count;

  logic [WIDTH:0]       w_shift;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_sub;
  logic                 w_pop;
  logic                 w_space;
  logic                 w_push;
  logic [WIDTH:0]       w_wdata;
  logic [WIDTH:0]       w_head;

  // Restoring step on the WIDTH+1 bit working remainder. The stored partial
  // remainder is always below the divisor, so the shifted value is below
  // twice the divisor and the difference fits back into WIDTH bits.
  assign w_shift = {r_prem, r_dvd[WIDTH-1]};
  assign w_ge    = w_shift[WIDTH] | (w_shift[WIDTH-1:0] >= r_dvs);
  assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

  // A pop frees a slot on the same edge, so a full buffer still accepts a
  // push when the head is being consumed.
  assign w_pop   = ReceiveData && (r_count != '0);
  assign w_space = (r_count != NW'(DEPTH)) || w_pop;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= GET_A;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    ReadyToAccept = 1'b0;
    w_push        = 1'b0;
    w_wdata       = {r_dz, r_quot};
    case (r_state)
      GET_A: begin
        ReadyToAccept = 1'b1;
        if (StartData) w_next = GET_B;
      end
      GET_B: begin
        ReadyToAccept = 1'b1;
        if (StartData) w_next = (InputData == '0) ? PUSH_Q : CALC;
      end
      CALC: begin
        if (r_cnt == '0) w_next = PUSH_Q;
      end
      PUSH_Q: begin
        w_push = w_space;
`ifdef ACC_DIV_REMAINDER_EN
        if (w_space) w_next = PUSH_R;
`else
        if (w_space) w_next = GET_A;
`endif
      end
`ifdef ACC_DIV_REMAINDER_EN
      PUSH_R: begin
        w_push  = w_space;
        w_wdata = {r_dz, r_prem};
        if (w_space) w_next = GET_A;
      end
`endif
      default: w_next = GET_A;
    endcase
  end

  // Operand capture and divider iteration
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_prem <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        GET_A: begin
          if (StartData) r_dvd <= InputData;
        end
        GET_B: begin
          if (StartData) begin
            r_dvs <= InputData;
            r_cnt <= CW'(WIDTH-1);
            if (InputData == '0) begin
              // Zero divisor: saturated quotient, remainder is the dividend.
              r_dz   <= 1'b1;
              r_quot <= '1;
              r_prem <= r_dvd;
            end else begin
              r_dz   <= 1'b0;
              r_quot <= '0;
              r_prem <= '0;
            end
          end
        end
        CALC: begin
          r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
          r_prem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_quot <= {r_quot[WIDTH-2:0], w_ge};
          r_cnt  <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result buffer storage; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head      = r_mem[r_rd];
  assign OutValid    = (r_count != '0);
  assign OutputData  = OutValid ? w_head[WIDTH-1:0] : '0;
  assign OutDivZero  = OutValid & w_head[WIDTH];
  assign OutBuffFull = (r_count == NW'(DEPTH));
  assign BuffCount   = r_count;

endmodule

// File: tb/tb_acc_div_stream.sv
// Self-checking bench for acc_div_stream. Expected results come from plain
// division on the submitted operand pairs, held in an ordered queue that
// stands for the buffer contents.
module tb_acc_div_stream;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NW    = $clog2(DEPTH+1);
  localparam int LIM   = 300;
`ifdef ACC_DIV_REMAINDER_EN
  localparam int ENT = 2;
`else
  localparam int ENT = 1;
`endif

  logic                 clk;
  logic                 rstN;
  logic                 StartData;
  logic [WIDTH-1:0]     InputData;
  logic                 ReadyToAccept;
  logic                 ReceiveData;
  logic [WIDTH-1:0]     OutputData;
  logic                 OutValid;
  logic                 OutDivZero;
  logic                 OutBuffFull;
  logic [NW-1:0]        BuffCount;

  int n_chk = 0;
  int n_bad = 0;
  logic [WIDTH:0] mq[$];

  acc_div_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN), .StartData(StartData), .InputData(InputData),
    .ReadyToAccept(ReadyToAccept), .ReceiveData(ReceiveData),
    .OutputData(OutputData), .OutValid(OutValid), .OutDivZero(OutDivZero),
    .OutBuffFull(OutBuffFull), .BuffCount(BuffCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called and returns just after a falling edge.
  task automatic send_word(input logic [WIDTH-1:0] w);
    int n = 0;
    while (!ReadyToAccept && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) check_val("send_ready_timeout", ReadyToAccept, 1);
    StartData = 1'b1;
    InputData = w;
    @(negedge clk);
    StartData = 1'b0;
  endtask

  task automatic submit_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (b == '0) begin
      mq.push_back({1'b1, {WIDTH{1'b1}}});
`ifdef ACC_DIV_REMAINDER_EN
      mq.push_back({1'b1, a});
`endif
    end else begin
      mq.push_back({1'b0, a / b});
`ifdef ACC_DIV_REMAINDER_EN
      mq.push_back({1'b0, a % b});
`endif
    end
    send_word(a);
    send_word(b);
  endtask

  task automatic pop_check(input string tag);
    logic [WIDTH:0] e;
    int n = 0;
    while (!OutValid && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_valid"}, OutValid, 1);
    e = (mq.size() > 0) ? mq.pop_front() : '0;
    check_val({tag, "_data"}, OutputData, e[WIDTH-1:0]);
    check_val({tag, "_dz"}, OutDivZero, e[WIDTH]);
    ReceiveData = 1'b1;
    @(negedge clk);
    ReceiveData = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    while (mq.size() > 0) pop_check(tag);
  endtask

  task automatic wait_count(input int want);
    int n = 0;
    while (BuffCount != NW'(want) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check_val("wait_count", BuffCount, want);
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    rstN = 1'b0; StartData = 1'b0; ReceiveData = 1'b0; InputData = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", ReadyToAccept, 1);
    check_val("rst_valid", OutValid, 0);
    check_val("rst_full", OutBuffFull, 0);
    check_val("rst_count", BuffCount, 0);
    check_val("rst_data", OutputData, 0);
    check_val("rst_dz", OutDivZero, 0);
    rstN = 1'b1;
    @(negedge clk);

    // Basic division and quotient latency
    submit_pair(8'd99, 8'd10);
    check_val("basic_busy", ReadyToAccept, 0);
    repeat (WIDTH) @(negedge clk);
    check_val("basic_early", OutValid, 0);
    @(negedge clk);
    check_val("basic_on_time", OutValid, 1);
    check_val("basic_q", OutputData, 9);
    check_val("basic_cnt", BuffCount, 1);
    drain_all("basic");
    check_val("basic_empty", OutValid, 0);

    // Divide by zero
    submit_pair(8'd0, 8'd0);
    check_val("dz_early", OutValid, 0);
    @(negedge clk);
    check_val("dz_on_time", OutValid, 1);
    check_val("dz_q", OutputData, 8'hFF);
    check_val("dz_flag", OutDivZero, 1);
    submit_pair(8'd0, 8'd10);
    drain_all("dz");
    check_val("dz_empty", OutValid, 0);

`ifdef ACC_DIV_REMAINDER_EN
    submit_pair(8'd99, 8'd10);
    submit_pair(8'd200, 8'd7);
    wait_count(4);
    drain_all("rem");
`endif

    // Randomized pairs with irregular draining
    for (int i = 0; i < 30; i++) begin
      while (mq.size() > DEPTH - ENT) pop_check("rnd");
      a = WIDTH'($urandom);
      b = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
      submit_pair(a, b);
      if ($urandom_range(0, 1) == 1) pop_check("rnd");
    end
    drain_all("rnd");

    // Back-pressure
    for (int i = 0; i < DEPTH / ENT; i++) submit_pair(8'd50, 8'd5);
    wait_count(DEPTH);
    check_val("bp_full", OutBuffFull, 1);
    submit_pair(8'd50, 8'd5);
    repeat (WIDTH + 2) @(negedge clk);
    check_val("bp_stall_ready", ReadyToAccept, 0);
    check_val("bp_stall_cnt", BuffCount, DEPTH);
    StartData = 1'b1; InputData = 8'd77;
    @(negedge clk);
    StartData = 1'b0;
    check_val("bp_ignored", ReadyToAccept, 0);
    pop_check("bp");
    check_val("bp_cnt_after", BuffCount, DEPTH);
`ifdef ACC_DIV_REMAINDER_EN
    check_val("bp_rem_stall", ReadyToAccept, 0);
    pop_check("bp2");
    check_val("bp_cnt_after2", BuffCount, DEPTH);
`endif
    check_val("bp_ready_again", ReadyToAccept, 1);
    drain_all("bp_drain");
    submit_pair(8'd100, 8'd4);
    drain_all("bp_next");

    // Pointer wrap with alternating push and pop
    for (int i = 0; i < 9; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
      submit_pair(a, b);
      for (int k = 0; k < ENT; k++) begin
        check_val("wrap_cnt_bound", (BuffCount <= NW'(ENT)), 1);
        pop_check("wrap");
      end
    end
    check_val("wrap_empty", BuffCount, 0);

    // Reset in the middle of a division
    submit_pair(8'd20, 8'd4);
    submit_pair(8'd30, 8'd3);
    wait_count(2 * ENT);
    send_word(8'd200);
    send_word(8'd7);
    repeat (3) @(negedge clk);
    check_val("mid_busy", ReadyToAccept, 0);
    #2 rstN = 1'b0;
    #1;
    check_val("mid_rst_valid", OutValid, 0);
    check_val("mid_rst_cnt", BuffCount, 0);
    check_val("mid_rst_ready", ReadyToAccept, 1);
    check_val("mid_rst_data", OutputData, 0);
    check_val("mid_rst_dz", OutDivZero, 0);
    check_val("mid_rst_full", OutBuffFull, 0);
    mq.delete();
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    submit_pair(8'd100, 8'd3);
    drain_all("post_rst");
    check_val("post_rst_empty", OutValid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
